// File: rtl/gamepad_wb_pkg.sv
// Shared constants for the gamepad scanner: register map, CSR bit positions
// and the scan FSM encoding.
package gamepad_wb_pkg;

  localparam logic [3:0] ADDR_CSR = 4'd0;

  localparam int CSR_AUTO = 0;
  localparam int CSR_TRIG = 1;
  localparam int CSR_BUSY = 2;
  localparam int CSR_NEW  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_SEL_SW,
    ST_DONE
  } gp_state_e;

endpackage

// File: rtl/gamepad_phy.sv
// Pad-side scan engine: tick divider, latch/clock sequencing across both
// gp_sel phases, and per-pad shift buffers handed to the wrapper on done.
module gamepad_phy #(
  parameter int N_PORTS = 2,
  parameter int N_BITS  = 16,
  parameter int SEL_EN  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [7:0]                            div,
  input  logic                                  start,
  output logic                                  accept,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  tick,
  output logic [2*N_PORTS-1:0][N_BITS-1:0]      shadow,
  output logic                                  gp_sel,
  output logic                                  gp_latch,
  output logic                                  gp_clk,
  input  logic [N_PORTS-1:0]                    gp_data
);
  import gamepad_wb_pkg::*;

  localparam logic [3:0] LAST = 4'(N_BITS - 1);

  gp_state_e   state;
  logic [7:0]  cnt;
  logic [7:0]  div_q;
  logic        lat2;
  logic [3:0]  bit_cnt;
  logic        sample;

  // >= so a divider shrunk while idle cannot make the counter overshoot
  assign tick   = (cnt >= div_q);
  assign accept = (state == ST_IDLE) && start;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign sample = tick && (state == ST_GAP || state == ST_BIT_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (accept || tick)  cnt <= '0;
    else                      cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_q    <= '0;
      lat2     <= 1'b0;
      bit_cnt  <= '0;
      gp_sel   <= 1'b0;
      gp_latch <= 1'b0;
      gp_clk   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          div_q <= div;
          if (start) begin
            state    <= ST_LATCH;
            gp_latch <= 1'b1;
            lat2     <= 1'b0;
            gp_sel   <= 1'b0;
          end
        end
        ST_LATCH: if (tick) begin
          if (lat2) begin
            state    <= ST_GAP;
            gp_latch <= 1'b0;
          end else begin
            lat2 <= 1'b1;
          end
        end
        ST_GAP: if (tick) begin
          state   <= ST_BIT_LO;
          gp_clk  <= 1'b0;
          bit_cnt <= 4'd1;
        end
        ST_BIT_LO: if (tick) begin
          state  <= ST_BIT_HI;
          gp_clk <= 1'b1;
        end
        ST_BIT_HI: if (tick) begin
          if (bit_cnt == LAST) begin
            if (SEL_EN != 0 && !gp_sel) begin
              state  <= ST_SEL_SW;
              gp_sel <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            state   <= ST_BIT_LO;
            gp_clk  <= 1'b0;
          end
        end
        ST_SEL_SW: if (tick) begin
          state    <= ST_LATCH;
          gp_latch <= 1'b1;
          lat2     <= 1'b0;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          gp_sel <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pads shift LSB first; after N_BITS samples the first bit sits at [0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (sample) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (!gp_sel) shadow[p]         <= {~gp_data[p], shadow[p][N_BITS-1:1]};
        else         shadow[N_PORTS+p] <= {~gp_data[p], shadow[N_PORTS+p][N_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/gamepad_wb.sv
// Wishbone CSR front end for the serial gamepad scanner: control/status,
// auto-poll period counter, start coalescing and committed pad data.
module gamepad_wb #(
  parameter int         N_PORTS = 2,
  parameter int         N_BITS  = 16,
  parameter int         SEL_EN  = 1,
  parameter logic [7:0] DIV_RST = 8'd47
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         wb_addr,
  input  logic [31:0]        wb_wdata,
  output logic [31:0]        wb_rdata,
  input  logic               wb_we,
  input  logic               wb_cyc,
  output logic               wb_ack,
  output logic               gp_sel,
  input  logic [N_PORTS-1:0] gp_data,
  output logic               gp_latch,
  output logic               gp_clk
);
  import gamepad_wb_pkg::*;

  localparam int N_PADS = (SEL_EN != 0) ? 2 * N_PORTS : N_PORTS;
  localparam int N_REGS = (N_PADS + 1) / 2;

  logic                               auto_en, new_flag;
  logic [7:0]                         div;
  logic [15:0]                        period;
  logic [23:0]                        pcnt;
  logic                               pend_trig, pend_auto;
  logic [2*N_REGS-1:0][15:0]          pad_q;
  logic [2*N_PORTS-1:0][N_BITS-1:0]   shadow;
  logic                               accept, busy, done, tick;
  logic                               acc, wr_csr, trig, auto_fire;
  logic [31:0]                        csr_val, rd_mux;
  logic                               unused_ok;

  assign acc       = wb_cyc && !wb_ack;
  assign wr_csr    = acc && wb_we && (wb_addr == ADDR_CSR);
  assign trig      = wr_csr && wb_wdata[CSR_TRIG];
  assign auto_fire = auto_en && tick && (pcnt >= {period, 8'hFF});
  assign csr_val   = {period, div, 4'b0, new_flag, busy, 1'b0, auto_en};
  assign unused_ok = &{1'b0, wb_wdata[7:4], wb_wdata[CSR_BUSY]};

  gamepad_phy #(.N_PORTS(N_PORTS), .N_BITS(N_BITS), .SEL_EN(SEL_EN)) u_phy (
    .clk      (clk),
    .rst      (rst),
    .div      (div),
    .start    (pend_trig || pend_auto),
    .accept   (accept),
    .busy     (busy),
    .done     (done),
    .tick     (tick),
    .shadow   (shadow),
    .gp_sel   (gp_sel),
    .gp_latch (gp_latch),
    .gp_clk   (gp_clk),
    .gp_data  (gp_data)
  );

  always_comb begin
    rd_mux = '0;
    if (wb_addr == ADDR_CSR) rd_mux = csr_val;
    for (int k = 0; k < N_REGS; k++)
      if (wb_addr == 4'(k + 1)) rd_mux = {pad_q[2*k+1], pad_q[2*k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack   <= acc;
      wb_rdata <= acc ? rd_mux : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_en <= 1'b0;
      div     <= DIV_RST;
      period  <= '0;
    end else if (wr_csr) begin
      auto_en <= wb_wdata[CSR_AUTO];
      div     <= wb_wdata[15:8];
      period  <= wb_wdata[31:16];
    end
  end

  // Period counts ticks whether or not a scan is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pcnt <= '0;
    else if (!auto_en) pcnt <= '0;
    else if (tick)     pcnt <= auto_fire ? 24'd0 : pcnt + 24'd1;
  end

  // Two flags so that dropping auto_en can discard only the auto request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_trig <= 1'b0;
      pend_auto <= 1'b0;
    end else begin
      pend_trig <= (pend_trig && !accept) || trig;
      pend_auto <= auto_en && ((pend_auto && !accept) || auto_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_flag <= 1'b0;
      pad_q    <= '0;
    end else if (done) begin
      new_flag <= 1'b1;
      for (int i = 0; i < N_PADS; i++) pad_q[i] <= 16'(shadow[i]);
    end else if (wr_csr && wb_wdata[CSR_NEW]) begin
      new_flag <= 1'b0;
    end
  end

endmodule
